uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter among the response sources inside the connector: master, EEPROM, AD7782 and ADT7301 slaves. It grants the transmitter for a whole packet, so multi-byte responses are never interleaved. It sequences each byte through the UART `tx_start`/`tx_busy` handshake. A stalled source is released after a configurable idle timeout.

---
 rtl/uart_tx_arbiter_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the connector's UART transmit arbiter.
package connector_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        SETTLE,
        WAIT_DONE,
        HOLD
    } arb_state_t;

    typedef logic [7:0] byte_t;

    localparam int REQ_MSTR    = 0;
    localparam int REQ_EEPROM  = 1;
    localparam int REQ_AD7782  = 2;
    localparam int REQ_ADT7301 = 3;

    // Width of a counter/index able to hold 0..n-1, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester handshake and UART transmit signals shared by the arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    import connector_pkg::*;

    logic  [N_REQ-1:0] req;
    byte_t [N_REQ-1:0] req_data;
    logic  [N_REQ-1:0] req_last;
    logic  [N_REQ-1:0] ack;
    logic  [N_REQ-1:0] grant;
    byte_t             tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              timeout_err;
    logic              busy;

    modport master (
        input  req, req_data, req_last, tx_busy,
        output ack, grant, tx_data, tx_start, timeout_err, busy
    );

    modport slave (
        output req, req_data, req_last, tx_busy,
        input  ack, grant, tx_data, tx_start, timeout_err, busy
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above last_owner, wrapping.
module rr_pick
    import connector_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idxWidth(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_owner,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    winner_idx
);

    logic [IW-1:0] cand;
    logic          found;

    // Walk upward from the previous owner so it gets the lowest priority this round.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = last_owner;
        for (int off = 0; off < N_REQ; off++) begin
            cand = (cand == IW'(N_REQ - 1)) ? '0 : cand + 1'b1;
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among the
// connector's response sources, with an idle timeout for stalled owners.
module uart_tx_arbiter
    import connector_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 50000
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.master bus
);

    localparam int            IW      = idxWidth(N_REQ);
    localparam int            CW      = idxWidth(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    lastOwner_q, lastOwner_d;
    byte_t            txData_q, txData_d;
    logic             lastFlag_q, lastFlag_d;
    logic [CW-1:0]    idleCnt_q, idleCnt_d;
    logic             timeoutErr_q, timeoutErr_d;

    logic [N_REQ-1:0] pickOnehot;
    logic [IW-1:0]    pickIdx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req        (bus.req),
        .last_owner (lastOwner_q),
        .winner     (pickOnehot),
        .winner_idx (pickIdx)
    );

    // State and datapath registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            lastOwner_q  <= IW'(N_REQ - 1);
            txData_q     <= '0;
            lastFlag_q   <= 1'b0;
            idleCnt_q    <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            lastOwner_q  <= lastOwner_d;
            txData_q     <= txData_d;
            lastFlag_q   <= lastFlag_d;
            idleCnt_q    <= idleCnt_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    // Next-state logic: hold the grant across a packet, release on last byte or timeout.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        lastOwner_d  = lastOwner_q;
        txData_d     = txData_q;
        lastFlag_d   = lastFlag_q;
        idleCnt_d    = idleCnt_q;
        timeoutErr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req != '0) begin
                    state_d    = SEND;
                    grant_d    = pickOnehot;
                    owner_d    = pickIdx;
                    txData_d   = bus.req_data[pickIdx];
                    lastFlag_d = bus.req_last[pickIdx];
                end
            end
            SEND: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (lastFlag_q) begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        lastOwner_d = owner_q;
                    end else begin
                        state_d   = HOLD;
                        idleCnt_d = '0;
                    end
                end
            end
            HOLD: begin
                if (bus.req[owner_q]) begin
                    state_d    = SEND;
                    txData_d   = bus.req_data[owner_q];
                    lastFlag_d = bus.req_last[owner_q];
                end else if (idleCnt_q == CNT_MAX) begin
                    state_d      = IDLE;
                    grant_d      = '0;
                    lastOwner_d  = owner_q;
                    timeoutErr_d = 1'b1;
                end else begin
                    idleCnt_d = idleCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.tx_data     = txData_q;
    assign bus.tx_start    = (state_q == SEND);
    assign bus.ack         = (state_q == SEND) ? grant_q : '0;
    assign bus.busy        = |grant_q;
    assign bus.timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for the UART transmit arbiter with a simple UART and requester model.
module tb_uart_tx_arbiter;
    import connector_pkg::*;

    localparam int N        = 4;
    localparam int TO       = 16;
    localparam int UART_LEN = 10;

    typedef logic [1:0] idx_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // UART model: busy for UART_LEN cycles starting the cycle after tx_start.
    int busyCnt;
    always @(posedge clk or negedge rst) begin
        if (!rst)                busyCnt <= 0;
        else if (bus.tx_start)   busyCnt <= UART_LEN;
        else if (busyCnt != 0)   busyCnt <= busyCnt - 1;
    end
    assign bus.tx_busy = (busyCnt != 0);

    int nVectors     = 0;
    int nMiscompares = 0;
    int cycleNo      = 0;

    byte_t      pktMem  [N][4];
    logic [3:0] lastMem [N];
    logic [1:0] pktLen  [N];
    logic [1:0] pktPos  [N];
    logic [N-1:0] ackSeen;

    byte_t        logData[$];
    int           logOwner[$];
    int           logCycle[$];
    int           toCycle[$];
    logic [N-1:0] toGrant[$];
    int           badAck      = 0;
    int           grantDrops  = 0;
    int           foreignGrant = 0;
    logic [N-1:0] prevGrant   = '0;
    logic [N-1:0] watchGrant  = '0;

    function automatic int ownerOf(input logic [N-1:0] a);
        int r = -1;
        if ($onehot(a))
            for (int k = 0; k < N; k++)
                if (a[idx_t'(k)]) r = k;
        return r;
    endfunction

    task automatic presentByte(input idx_t who);
        if (pktPos[who] < pktLen[who]) begin
            bus.req[who]      = 1'b1;
            bus.req_data[who] = pktMem[who][pktPos[who]];
            bus.req_last[who] = lastMem[who][pktPos[who]];
        end else begin
            bus.req[who]      = 1'b0;
            bus.req_last[who] = 1'b0;
        end
    endtask

    task automatic loadPacket(input idx_t who, input logic [1:0] len, input byte_t b0,
                              input byte_t b1, input byte_t b2, input bit lastAtEnd);
        pktMem[who][0] = b0;
        pktMem[who][1] = b1;
        pktMem[who][2] = b2;
        lastMem[who]   = '0;
        if (lastAtEnd) lastMem[who][len - 2'd1] = 1'b1;
        pktLen[who] = len;
        pktPos[who] = 2'd0;
        presentByte(who);
    endtask

    task automatic clearLog();
        logData.delete();
        logOwner.delete();
        logCycle.delete();
        toCycle.delete();
        toGrant.delete();
        grantDrops   = 0;
        foreignGrant = 0;
    endtask

    // One clock: requesters advance the cycle after their ack, then outputs are logged.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        cycleNo++;
        for (int k = 0; k < N; k++) begin
            if (ackSeen[idx_t'(k)]) begin
                ackSeen[idx_t'(k)] = 1'b0;
                pktPos[idx_t'(k)]  = pktPos[idx_t'(k)] + 2'd1;
                presentByte(idx_t'(k));
            end
            if (bus.ack[idx_t'(k)]) ackSeen[idx_t'(k)] = 1'b1;
        end
        if (bus.tx_start) begin
            logData.push_back(bus.tx_data);
            logOwner.push_back(ownerOf(bus.ack));
            logCycle.push_back(cycleNo);
            if (bus.ack != bus.grant) badAck++;
        end else if (bus.ack != '0) begin
            badAck++;
        end
        if (bus.timeout_err) begin
            toCycle.push_back(cycleNo);
            toGrant.push_back(bus.grant);
        end
        if (prevGrant != '0 && bus.grant == '0) grantDrops++;
        if (bus.grant != '0 && bus.grant != watchGrant) foreignGrant++;
        prevGrant = bus.grant;
    endtask

    task automatic runUntilIdle(input int maxCycles, output bit done);
        done = 1'b0;
        for (int c = 0; c < maxCycles && !done; c++) begin
            stepCycle();
            if (bus.grant == '0 && bus.req == '0 && ackSeen == '0) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        ackSeen      = '0;
        for (int k = 0; k < N; k++) begin
            pktLen[idx_t'(k)] = '0;
            pktPos[idx_t'(k)] = '0;
        end
        #2 rst = 1'b0;
        repeat (3) stepCycle();
        nVectors++; if (bus.grant !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL reset_grant: got %b expected 0000", bus.grant); end
        nVectors++; if (bus.ack !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL reset_ack: got %b expected 0000", bus.ack); end
        nVectors++; if (bus.tx_start !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
        nVectors++; if (bus.tx_data !== 8'h00) begin nMiscompares++; $display("[TB] FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
        nVectors++; if (bus.busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        nVectors++; if (bus.timeout_err !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", bus.timeout_err); end
        rst = 1'b1;
        stepCycle();
        nVectors++; if (bus.grant !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL idle_grant: got %b expected 0000", bus.grant); end
    endtask

    task automatic test_latency();
        bit done;
        clearLog();
        loadPacket(idx_t'(REQ_AD7782), 2'd1, 8'h7E, 8'h00, 8'h00, 1'b1);
        nVectors++; if (bus.tx_start !== 1'b0) begin nMiscompares++; $display("[TB] FAIL latency_pre_start: got %b expected 0", bus.tx_start); end
        stepCycle();
        nVectors++; if (bus.tx_start !== 1'b1) begin nMiscompares++; $display("[TB] FAIL latency_start: got %b expected 1", bus.tx_start); end
        nVectors++; if (bus.tx_data !== 8'h7E) begin nMiscompares++; $display("[TB] FAIL latency_data: got %h expected 7e", bus.tx_data); end
        nVectors++; if (bus.ack !== 4'b0100) begin nMiscompares++; $display("[TB] FAIL latency_ack: got %b expected 0100", bus.ack); end
        nVectors++; if (bus.grant !== 4'b0100 || bus.busy !== 1'b1) begin nMiscompares++; $display("[TB] FAIL latency_grant: got %b/%b expected 0100/1", bus.grant, bus.busy); end
        runUntilIdle(100, done);
        nVectors++; if (done !== 1'b1) begin nMiscompares++; $display("[TB] FAIL latency_release: got busy=%b expected idle within 100 cycles", bus.busy); end
    endtask

    task automatic test_contention();
        bit    done;
        int    expOwner[8] = '{0, 0, 2, 2, 0, 0, 2, 2};
        byte_t expData[8]  = '{8'h01, 8'h02, 8'h21, 8'h22, 8'h03, 8'h04, 8'h23, 8'h24};
        clearLog();
        loadPacket(idx_t'(REQ_MSTR), 2'd2, 8'h01, 8'h02, 8'h00, 1'b1);
        loadPacket(idx_t'(REQ_AD7782), 2'd2, 8'h21, 8'h22, 8'h00, 1'b1);
        runUntilIdle(200, done);
        nVectors++; if (done !== 1'b1) begin nMiscompares++; $display("[TB] FAIL contention_done1: got not idle expected idle within 200 cycles"); end
        loadPacket(idx_t'(REQ_MSTR), 2'd2, 8'h03, 8'h04, 8'h00, 1'b1);
        loadPacket(idx_t'(REQ_AD7782), 2'd2, 8'h23, 8'h24, 8'h00, 1'b1);
        runUntilIdle(200, done);
        nVectors++; if (done !== 1'b1) begin nMiscompares++; $display("[TB] FAIL contention_done2: got not idle expected idle within 200 cycles"); end
        nVectors++; if (logOwner.size() != 8) begin nMiscompares++; $display("[TB] FAIL contention_count: got %0d starts expected 8", logOwner.size()); end
        for (int k = 0; k < 8; k++) begin
            if (k < logOwner.size()) begin
                nVectors++; if (logOwner[k] != expOwner[k]) begin nMiscompares++; $display("[TB] FAIL contention_owner[%0d]: got %0d expected %0d", k, logOwner[k], expOwner[k]); end
                nVectors++; if (logData[k] !== expData[k]) begin nMiscompares++; $display("[TB] FAIL contention_data[%0d]: got %h expected %h", k, logData[k], expData[k]); end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (k + 1 < logCycle.size()) begin
                nVectors++; if (logCycle[k+1] - logCycle[k] != 13) begin nMiscompares++; $display("[TB] FAIL contention_gap[%0d]: got %0d cycles expected 13", k, logCycle[k+1] - logCycle[k]); end
            end
        end
    endtask

    task automatic test_single_packet();
        bit    done;
        byte_t expData[3] = '{8'hA5, 8'h5A, 8'h3C};
        clearLog();
        watchGrant = 4'b0010;
        loadPacket(idx_t'(REQ_EEPROM), 2'd3, 8'hA5, 8'h5A, 8'h3C, 1'b1);
        runUntilIdle(200, done);
        nVectors++; if (done !== 1'b1) begin nMiscompares++; $display("[TB] FAIL single_done: got not idle expected idle within 200 cycles"); end
        nVectors++; if (logData.size() != 3) begin nMiscompares++; $display("[TB] FAIL single_count: got %0d starts expected 3", logData.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < logData.size()) begin
                nVectors++; if (logData[k] !== expData[k]) begin nMiscompares++; $display("[TB] FAIL single_data[%0d]: got %h expected %h", k, logData[k], expData[k]); end
                nVectors++; if (logOwner[k] != 1) begin nMiscompares++; $display("[TB] FAIL single_ack[%0d]: got owner %0d expected 1", k, logOwner[k]); end
            end
        end
        nVectors++; if (grantDrops != 1) begin nMiscompares++; $display("[TB] FAIL single_grant_drops: got %0d expected 1", grantDrops); end
        nVectors++; if (foreignGrant != 0) begin nMiscompares++; $display("[TB] FAIL single_grant_value: got %0d bad cycles expected 0", foreignGrant); end
        nVectors++; if (bus.grant !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL single_final_grant: got %b expected 0000", bus.grant); end
    endtask

    task automatic test_lockout();
        bit    done;
        int    expOwner[4] = '{1, 1, 1, 2};
        byte_t expData[4]  = '{8'hB1, 8'hB2, 8'hB3, 8'hC1};
        clearLog();
        loadPacket(idx_t'(REQ_EEPROM), 2'd3, 8'hB1, 8'hB2, 8'hB3, 1'b1);
        stepCycle();
        loadPacket(idx_t'(REQ_AD7782), 2'd1, 8'hC1, 8'h00, 8'h00, 1'b1);
        runUntilIdle(200, done);
        nVectors++; if (done !== 1'b1) begin nMiscompares++; $display("[TB] FAIL lockout_done: got not idle expected idle within 200 cycles"); end
        nVectors++; if (logOwner.size() != 4) begin nMiscompares++; $display("[TB] FAIL lockout_count: got %0d starts expected 4", logOwner.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < logOwner.size()) begin
                nVectors++; if (logOwner[k] != expOwner[k]) begin nMiscompares++; $display("[TB] FAIL lockout_owner[%0d]: got %0d expected %0d", k, logOwner[k], expOwner[k]); end
                nVectors++; if (logData[k] !== expData[k]) begin nMiscompares++; $display("[TB] FAIL lockout_data[%0d]: got %h expected %h", k, logData[k], expData[k]); end
            end
        end
    endtask

    task automatic test_timeout();
        bit done;
        clearLog();
        loadPacket(idx_t'(REQ_ADT7301), 2'd1, 8'h11, 8'h00, 8'h00, 1'b0);
        stepCycle();
        loadPacket(idx_t'(REQ_MSTR), 2'd1, 8'h0A, 8'h00, 8'h00, 1'b1);
        runUntilIdle(200, done);
        nVectors++; if (done !== 1'b1) begin nMiscompares++; $display("[TB] FAIL timeout_done: got not idle expected idle within 200 cycles"); end
        nVectors++; if (toCycle.size() != 1) begin nMiscompares++; $display("[TB] FAIL timeout_pulses: got %0d expected 1", toCycle.size()); end
        nVectors++; if (logOwner.size() != 2) begin nMiscompares++; $display("[TB] FAIL timeout_starts: got %0d expected 2", logOwner.size()); end
        if (toCycle.size() == 1 && logOwner.size() == 2) begin
            nVectors++; if (logOwner[0] != 3 || logData[0] !== 8'h11) begin nMiscompares++; $display("[TB] FAIL timeout_first: got owner %0d data %h expected 3/11", logOwner[0], logData[0]); end
            nVectors++; if (toCycle[0] - logCycle[0] != 28) begin nMiscompares++; $display("[TB] FAIL timeout_delay: got %0d cycles after send expected 28", toCycle[0] - logCycle[0]); end
            nVectors++; if (toGrant[0] !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL timeout_grant: got %b expected 0000", toGrant[0]); end
            nVectors++; if (logCycle[1] != toCycle[0] + 1) begin nMiscompares++; $display("[TB] FAIL timeout_next_grant: got cycle %0d expected %0d", logCycle[1], toCycle[0] + 1); end
            nVectors++; if (logOwner[1] != 0 || logData[1] !== 8'h0A) begin nMiscompares++; $display("[TB] FAIL timeout_next_owner: got owner %0d data %h expected 0/0a", logOwner[1], logData[1]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        bit done;
        clearLog();
        loadPacket(idx_t'(REQ_EEPROM), 2'd3, 8'hD1, 8'hD2, 8'hD3, 1'b1);
        repeat (5) stepCycle();
        #2 rst = 1'b0;
        #1;
        nVectors++; if (bus.grant !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL midreset_grant: got %b expected 0000", bus.grant); end
        nVectors++; if (bus.ack !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL midreset_ack: got %b expected 0000", bus.ack); end
        nVectors++; if (bus.tx_start !== 1'b0) begin nMiscompares++; $display("[TB] FAIL midreset_tx_start: got %b expected 0", bus.tx_start); end
        nVectors++; if (bus.busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy); end
        bus.req      = '0;
        bus.req_last = '0;
        ackSeen      = '0;
        for (int k = 0; k < N; k++) begin
            pktLen[idx_t'(k)] = '0;
            pktPos[idx_t'(k)] = '0;
        end
        repeat (2) stepCycle();
        rst = 1'b1;
        clearLog();
        loadPacket(idx_t'(REQ_ADT7301), 2'd1, 8'hE3, 8'h00, 8'h00, 1'b1);
        loadPacket(idx_t'(REQ_MSTR), 2'd1, 8'hE0, 8'h00, 8'h00, 1'b1);
        runUntilIdle(200, done);
        nVectors++; if (done !== 1'b1) begin nMiscompares++; $display("[TB] FAIL midreset_done: got not idle expected idle within 200 cycles"); end
        nVectors++; if (logOwner.size() != 2) begin nMiscompares++; $display("[TB] FAIL midreset_count: got %0d starts expected 2", logOwner.size()); end
        if (logOwner.size() == 2) begin
            nVectors++; if (logOwner[0] != 0 || logData[0] !== 8'hE0) begin nMiscompares++; $display("[TB] FAIL midreset_first: got owner %0d data %h expected 0/e0", logOwner[0], logData[0]); end
            nVectors++; if (logOwner[1] != 3 || logData[1] !== 8'hE3) begin nMiscompares++; $display("[TB] FAIL midreset_second: got owner %0d data %h expected 3/e3", logOwner[1], logData[1]); end
        end
        nVectors++; if (toCycle.size() != 0) begin nMiscompares++; $display("[TB] FAIL midreset_timeout_err: got %0d pulses expected 0", toCycle.size()); end
    endtask

    task automatic test_ack_protocol();
        nVectors++; if (badAck != 0) begin nMiscompares++; $display("[TB] FAIL ack_protocol: got %0d bad ack cycles expected 0", badAck); end
    endtask

    initial begin
        $display("[TB] starting uart_tx_arbiter bench");
        test_reset();
        test_latency();
        test_contention();
        test_single_packet();
        test_lockout();
        test_timeout();
        test_reset_mid_packet();
        test_ack_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
